uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- Parametrised successor to the team's basic UART receiver.
- Adds 16x-style oversampling with 3-sample majority vote per bit, a 2-flop input synchroniser and configurable data width, parity mode and stop bit count.
- Adds framing-error and break detection, and false-start rejection.
- Sits behind the board RX pin and feeds the command/FIFO logic through a one-cycle rx_valid strobe.

Parameters:
- DATA, 8, data bits per frame (5..9), LSB received first.
- OVERSAMPLE, 16, sample ticks per bit period (even, >= 4).
- BAUD_DIV, 27, clk cycles per sample tick (>= 1); 50 MHz / (115200*16) ≈ 27.
- PARITY_EN, 1, 1 = parity bit present after data, 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0).
- STOP_BITS, 1, number of stop bits checked (1 or 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx_in  input  1  asynchronous serial line, idle high.
- rx_data  output  DATA  last received data word.
- rx_valid  output  1  one-clk pulse, frame complete.
- parity_error  output  1  status of last frame; valid with rx_valid, held until next rx_valid.
- framing_error  output  1  a stop bit voted 0; valid with rx_valid, held until next rx_valid.
- break_detect  output  1  one-clk pulse with rx_valid when the whole frame was low.

Behaviour:
- Reset: async, effective immediately, including mid-frame. Clears:
  - state -> IDLE;
  - all counters -> 0;
  - synchroniser flops -> 1;
  - rx_data = 0, rx_valid = 0, parity_error = 0, framing_error = 0, break_detect = 0.
- Synchroniser: rx_in passes through 2 flops (rx_s). All decisions use rx_s.
- Tick generator:
  - Free-running divider counts 0..BAUD_DIV-1.
  - os_tick pulses one clk when the count = BAUD_DIV-1.
  - It is never restarted by frame activity.
- Sample counter: scnt counts 0..OVERSAMPLE-1 on os_tick and wraps to 0 at the bit boundary.
- Bit value: majority of rx_s sampled on os_ticks at scnt = M-1, M and M+1, where M = OVERSAMPLE/2. Two of three decides. The vote is taken on the os_tick at scnt = M+1.
- States:
  - IDLE: on os_tick with rx_s = 0 -> START, scnt = 0.
  - START:
    - At vote, 1 = false start -> IDLE (no outputs change).
    - At vote, 0 -> remain until scnt = OVERSAMPLE-1, then -> DATA with bit_cnt = 0 and parity accumulator = PARITY_ODD.
  - DATA:
    - At vote, shift the bit in (MSB side, shift right) and XOR it into the accumulator.
    - At scnt = OVERSAMPLE-1: if bit_cnt = DATA-1, go -> PARITY when PARITY_EN = 1, else -> STOP. Otherwise bit_cnt + 1.
  - PARITY:
    - At vote, pe = (accumulator XOR voted bit) != 0. The accumulator's PARITY_ODD seed makes even/odd uniform.
    - At scnt = OVERSAMPLE-1 -> STOP.
  - STOP:
    - At vote, a 0 sets the frame's fe flag.
    - If this is the last stop bit, complete the frame at this vote, without waiting for bit end, so the receiver resyncs early.
    - Otherwise, at scnt = OVERSAMPLE-1 start the second stop bit.
  - WAIT_HIGH: entered after a completed frame with fe = 1. Leave to IDLE on the first os_tick with rx_s = 1. This prevents a held-low line (break) from re-triggering.
- Frame completion, on the clk after the final stop vote:
  - rx_data <= shift register; rx_valid = 1 for exactly one clk.
  - parity_error <= pe (0 if PARITY_EN = 0); framing_error <= fe.
  - break_detect = 1 for one clk if all data bits, the parity bit (if present) and every stop bit voted 0.
  - Next state: IDLE if fe = 0, else WAIT_HIGH.
  - Frames with errors are still delivered (rx_valid pulses).
- Widths:
  - bit_cnt is $clog2(DATA+1) bits.
  - scnt is $clog2(OVERSAMPLE) bits.
  - The divider is $clog2(BAUD_DIV+1) bits.
- Latency: rx_valid rises 1 clk after the os_tick carrying the last stop vote, i.e. about (1 + DATA + PARITY_EN + STOP_BITS - 0.5) bit periods after the start edge, plus 2 clk of synchroniser delay.
- Glitches: a single-tick glitch within a bit is outvoted. A low pulse shorter than M+1 ticks from start detection is rejected as a false start.

Test Plan:
- BAUD_DIV = 4, defaults; send 0xA5 with even parity bit 0 and stop 1 -> one rx_valid; rx_data = 0xA5; parity_error = 0; framing_error = 0; break_detect = 0.
- Same frame with parity bit 1 -> rx_data = 0xA5, parity_error = 1. Then a clean 0x3C -> parity_error returns to 0.
- Frame 0x5A with stop bit 0 -> rx_valid pulses, framing_error = 1. Line then held high for 1 bit -> FSM in IDLE; next 0x12 received cleanly.
- Line low for 3 sample ticks, then high -> no rx_valid; next valid 0x81 received correctly. A 1-tick low glitch inside a data bit of 0xFF still yields 0xFF.
- Line low for 20 bit periods, then high -> exactly one rx_valid with rx_data = 0x00, framing_error = 1, break_detect = 1; no second frame until the line returns high.
- DATA = 7, PARITY_ODD = 1, STOP_BITS = 2: send 0x55 with parity bit 1 and the second stop bit 0 -> rx_data = 0x55, parity_error = 0, framing_error = 1. Assert reset mid-data of the following frame -> all outputs 0 immediately; next frame is received correctly.

Source files
------------

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, free-running sample tick, 3-sample majority
// vote per bit, configurable data/parity/stop format with framing-error and break reporting.
module uart_rx_os #(
   parameter int DATA       = 8,
   parameter int OVERSAMPLE = 16,
   parameter int BAUD_DIV   = 27,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx_in,
   output logic [DATA-1:0] rx_data,
   output logic            rx_valid,
   output logic            parity_error,
   output logic            framing_error,
   output logic            break_detect
);

   localparam int M  = OVERSAMPLE / 2;
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA + 1);
   localparam int DW = $clog2(BAUD_DIV + 1);

   localparam logic [SW-1:0] SC_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] SC_V0   = SW'(M - 1);
   localparam logic [SW-1:0] SC_V1   = SW'(M);
   localparam logic [SW-1:0] SC_V2   = SW'(M + 1);
   localparam logic [DW-1:0] DV_LAST = DW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BC_LAST = BW'(DATA - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_HIGH
   } state_t;

   state_t            state_q, state_d;
   logic              rx_meta_q, rx_s_q;
   logic [DW-1:0]     div_q;
   logic [SW-1:0]     scnt_q, scnt_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic              stop_cnt_q, stop_cnt_d;
   logic [1:0]        smp_q, smp_d;
   logic [DATA-1:0]   shift_q, shift_d;
   logic              acc_q, acc_d;
   logic              pe_q, pe_d;
   logic              fe_q, fe_d;
   logic              zero_q, zero_d;
   logic [DATA-1:0]   rx_data_q, rx_data_d;
   logic              valid_q, valid_d;
   logic              perr_q, perr_d;
   logic              ferr_q, ferr_d;
   logic              brk_q, brk_d;

   logic os_tick, at_vote, at_end, vote, last_stop, fe_now, zero_now;

   assign os_tick   = (div_q == DV_LAST);
   assign at_vote   = os_tick && (scnt_q == SC_V2);
   assign at_end    = os_tick && (scnt_q == SC_LAST);
   // smp_q holds the M-1 and M samples; the live rx_s_q is the M+1 sample.
   assign vote      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
   assign last_stop = (STOP_BITS == 1) || stop_cnt_q;
   assign fe_now    = fe_q | ~vote;
   assign zero_now  = zero_q & ~vote;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         div_q     <= '0;
      end else begin
         rx_meta_q <= rx_in;
         rx_s_q    <= rx_meta_q;
         div_q     <= os_tick ? '0 : div_q + DW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         scnt_q     <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         smp_q      <= 2'b11;
         shift_q    <= '0;
         acc_q      <= 1'b0;
         pe_q       <= 1'b0;
         fe_q       <= 1'b0;
         zero_q     <= 1'b0;
         rx_data_q  <= '0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         brk_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         scnt_q     <= scnt_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         smp_q      <= smp_d;
         shift_q    <= shift_d;
         acc_q      <= acc_d;
         pe_q       <= pe_d;
         fe_q       <= fe_d;
         zero_q     <= zero_d;
         rx_data_q  <= rx_data_d;
         valid_q    <= valid_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         brk_q      <= brk_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      scnt_d     = scnt_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      smp_d      = smp_q;
      shift_d    = shift_q;
      acc_d      = acc_q;
      pe_d       = pe_q;
      fe_d       = fe_q;
      zero_d     = zero_q;
      rx_data_d  = rx_data_q;
      valid_d    = 1'b0;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      brk_d      = 1'b0;

      if (os_tick && state_q != ST_IDLE && state_q != ST_WAIT_HIGH) begin
         scnt_d = (scnt_q == SC_LAST) ? '0 : scnt_q + SW'(1);
         if (scnt_q == SC_V0) smp_d[0] = rx_s_q;
         if (scnt_q == SC_V1) smp_d[1] = rx_s_q;
      end

      case (state_q)
         ST_IDLE: begin
            scnt_d = '0;
            if (os_tick && !rx_s_q) state_d = ST_START;
         end
         ST_START: begin
            if (at_vote && vote) begin
               state_d = ST_IDLE;
               scnt_d  = '0;
            end else if (at_end) begin
               state_d    = ST_DATA;
               bit_cnt_d  = '0;
               stop_cnt_d = 1'b0;
               acc_d      = 1'(PARITY_ODD);
               pe_d       = 1'b0;
               fe_d       = 1'b0;
               zero_d     = 1'b1;
            end
         end
         ST_DATA: begin
            if (at_vote) begin
               shift_d = {vote, shift_q[DATA-1:1]};
               acc_d   = acc_q ^ vote;
               if (vote) zero_d = 1'b0;
            end
            if (at_end) begin
               if (bit_cnt_q == BC_LAST)
                  state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               else
                  bit_cnt_d = bit_cnt_q + BW'(1);
            end
         end
         ST_PARITY: begin
            if (at_vote) begin
               pe_d = acc_q ^ vote;
               if (vote) zero_d = 1'b0;
            end
            if (at_end) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (at_vote) begin
               fe_d   = fe_now;
               zero_d = zero_now;
               // Completing at the vote, not the bit end, lets the next start edge be caught early.
               if (last_stop) begin
                  rx_data_d = shift_q;
                  valid_d   = 1'b1;
                  perr_d    = (PARITY_EN != 0) ? pe_q : 1'b0;
                  ferr_d    = fe_now;
                  brk_d     = zero_now;
                  scnt_d    = '0;
                  state_d   = fe_now ? ST_WAIT_HIGH : ST_IDLE;
               end
            end
            if (at_end && !last_stop) stop_cnt_d = 1'b1;
         end
         ST_WAIT_HIGH: begin
            scnt_d = '0;
            if (os_tick && rx_s_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign rx_data       = rx_data_q;
   assign rx_valid      = valid_q;
   assign parity_error  = perr_q;
   assign framing_error = ferr_q;
   assign break_detect  = brk_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: two configurations (8E1 and 7O2) checked cycle by cycle against a
// frame-level model held in expected queues, plus literal spot checks.
module tb_uart_rx_os;

   localparam int BIT_CLK = 64;   // OVERSAMPLE 16 * BAUD_DIV 4

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic rx_a = 1'b1;
   logic rx_b = 1'b1;

   logic [7:0] rx_data_a;
   logic       rx_valid_a, parity_error_a, framing_error_a, break_detect_a;
   logic [6:0] rx_data_b;
   logic       rx_valid_b, parity_error_b, framing_error_b, break_detect_b;

   always #5 clk = ~clk;

   uart_rx_os #(.DATA(8), .OVERSAMPLE(16), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(0),
                .STOP_BITS(1)) dut_a (
      .clk(clk), .reset(reset), .rx_in(rx_a),
      .rx_data(rx_data_a), .rx_valid(rx_valid_a), .parity_error(parity_error_a),
      .framing_error(framing_error_a), .break_detect(break_detect_a));

   uart_rx_os #(.DATA(7), .OVERSAMPLE(16), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(1),
                .STOP_BITS(2)) dut_b (
      .clk(clk), .reset(reset), .rx_in(rx_b),
      .rx_data(rx_data_b), .rx_valid(rx_valid_b), .parity_error(parity_error_b),
      .framing_error(framing_error_b), .break_detect(break_detect_b));

   int checks_total = 0;
   int checks_passed = 0;

   // Entry layout: {brk, fe, pe, data[8:0]}
   logic [11:0] exp_a_q[$];
   logic [11:0] exp_b_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Frame-level model: what the receiver must report for a frame with these line bits.
   function automatic logic [11:0] model(input logic [8:0] d, input logic podd, input logic p,
                                         input logic [1:0] stops, input logic [1:0] stop_mask);
      logic pe, fe, brk;
      pe  = podd ^ (^d) ^ p;
      fe  = ((stops & stop_mask) != stop_mask);
      brk = (d == 9'd0) && !p && ((stops & stop_mask) == 2'b00);
      return {brk, fe, pe, d};
   endfunction

   // Compare processes: held status and one-cycle pulses checked on every cycle.
   logic [11:0] ea, eb;
   logic [7:0]  ha_data;
   logic [6:0]  hb_data;
   logic        ha_pe, ha_fe, hb_pe, hb_fe, brk_exp_a, brk_exp_b;
   int          valid_cnt_a = 0, valid_cnt_b = 0;
   logic        brk_seen_a = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         ha_data = '0; ha_pe = 1'b0; ha_fe = 1'b0;
      end else begin
         brk_exp_a = 1'b0;
         if (rx_valid_a) begin
            valid_cnt_a++;
            if (exp_a_q.size() == 0) begin
               checks_total++;
               $display("FAIL a_unexpected_valid: rx_valid with data 0x%0h, expected no frame", rx_data_a);
            end else begin
               ea = exp_a_q.pop_front();
               ha_data = ea[7:0]; ha_pe = ea[9]; ha_fe = ea[10]; brk_exp_a = ea[11];
            end
         end
         if (break_detect_a) brk_seen_a = 1'b1;
         check("a_rx_data", rx_data_a, ha_data);
         check("a_parity_error", parity_error_a, ha_pe);
         check("a_framing_error", framing_error_a, ha_fe);
         check("a_break_detect", break_detect_a, brk_exp_a);
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         hb_data = '0; hb_pe = 1'b0; hb_fe = 1'b0;
      end else begin
         brk_exp_b = 1'b0;
         if (rx_valid_b) begin
            valid_cnt_b++;
            if (exp_b_q.size() == 0) begin
               checks_total++;
               $display("FAIL b_unexpected_valid: rx_valid with data 0x%0h, expected no frame", rx_data_b);
            end else begin
               eb = exp_b_q.pop_front();
               hb_data = eb[6:0]; hb_pe = eb[9]; hb_fe = eb[10]; brk_exp_b = eb[11];
            end
         end
         check("b_rx_data", rx_data_b, hb_data);
         check("b_parity_error", parity_error_b, hb_pe);
         check("b_framing_error", framing_error_b, hb_fe);
         check("b_break_detect", break_detect_b, brk_exp_b);
      end
   end

   // Driver tasks: all line changes happen on the falling edge.
   task automatic set_rx(input int which, input logic v);
      if (which == 0) rx_a = v;
      else rx_b = v;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_frame(input int which, input logic [12:0] bits, input int nbits,
                              input int glitch_bit);
      for (int i = 0; i < nbits; i++) begin
         if (i == glitch_bit) begin
            set_rx(which, bits[i]);  idle(28);
            set_rx(which, ~bits[i]); idle(4);
            set_rx(which, bits[i]);  idle(BIT_CLK - 32);
         end else begin
            set_rx(which, bits[i]);
            idle(BIT_CLK);
         end
      end
      set_rx(which, 1'b1);
   endtask

   task automatic wait_drain(input int which);
      int n;
      n = 0;
      while (n < 4 * BIT_CLK && ((which == 0) ? exp_a_q.size() : exp_b_q.size()) != 0) begin
         @(negedge clk);
         n++;
      end
      check((which == 0) ? "a_frame_delivered" : "b_frame_delivered",
            (which == 0) ? exp_a_q.size() : exp_b_q.size(), 0);
   endtask

   task automatic send_a(input logic [7:0] d, input logic p, input logic s, input int glitch_bit);
      logic [12:0] bits;
      bits = '1;
      bits[0] = 1'b0; bits[8:1] = d; bits[9] = p; bits[10] = s;
      exp_a_q.push_back(model({1'b0, d}, 1'b0, p, {1'b1, s}, 2'b01));
      drive_frame(0, bits, 11, glitch_bit);
      idle(BIT_CLK);
      wait_drain(0);
   endtask

   task automatic send_b(input logic [6:0] d, input logic p, input logic s1, input logic s2);
      logic [12:0] bits;
      bits = '1;
      bits[0] = 1'b0; bits[7:1] = d; bits[8] = p; bits[9] = s1; bits[10] = s2;
      exp_b_q.push_back(model({2'b00, d}, 1'b1, p, {s2, s1}, 2'b11));
      drive_frame(1, bits, 11, -1);
      idle(BIT_CLK);
      wait_drain(1);
   endtask

   int vc;

   initial begin
      #2 reset = 1'b1;
      idle(4);
      check("reset_rx_valid", rx_valid_a, 0);
      check("reset_rx_data", rx_data_a, 0);
      check("reset_parity_error", parity_error_a, 0);
      check("reset_framing_error", framing_error_a, 0);
      check("reset_break_detect", break_detect_a, 0);
      check("reset_b_rx_data", rx_data_b, 0);
      #3 reset = 1'b0;
      idle(2 * BIT_CLK);

      // Clean 8E1 frame, then bad parity, then recovery.
      send_a(8'hA5, 1'b0, 1'b1, -1);
      check("lit_a5_data", rx_data_a, 8'hA5);
      check("lit_a5_pe", parity_error_a, 0);
      check("lit_a5_fe", framing_error_a, 0);
      send_a(8'hA5, 1'b1, 1'b1, -1);
      check("lit_a5_bad_pe", parity_error_a, 1);
      check("lit_a5_bad_data", rx_data_a, 8'hA5);
      send_a(8'h3C, 1'b0, 1'b1, -1);
      check("lit_3c_pe_clear", parity_error_a, 0);

      // Stop bit low, then a clean frame after one idle bit.
      send_a(8'h5A, 1'b0, 1'b0, -1);
      check("lit_5a_fe", framing_error_a, 1);
      send_a(8'h12, 1'b0, 1'b1, -1);
      check("lit_12_data", rx_data_a, 8'h12);
      check("lit_12_fe_clear", framing_error_a, 0);

      // False start: 3 sample ticks low.
      vc = valid_cnt_a;
      rx_a = 1'b0; idle(12);
      rx_a = 1'b1; idle(2 * BIT_CLK);
      check("false_start_no_valid", valid_cnt_a - vc, 0);
      send_a(8'h81, 1'b0, 1'b1, -1);
      check("lit_81_data", rx_data_a, 8'h81);

      // One-tick glitch in data bit 3 (line bit 4) of 0xFF.
      send_a(8'hFF, 1'b0, 1'b1, 4);
      check("lit_ff_glitch_data", rx_data_a, 8'hFF);

      // Break: 20 bit periods low.
      vc = valid_cnt_a;
      brk_seen_a = 1'b0;
      exp_a_q.push_back(model(9'd0, 1'b0, 1'b0, 2'b10, 2'b01));
      rx_a = 1'b0; idle(20 * BIT_CLK);
      rx_a = 1'b1; idle(2 * BIT_CLK);
      wait_drain(0);
      check("break_one_valid", valid_cnt_a - vc, 1);
      check("lit_break_data", rx_data_a, 8'h00);
      check("lit_break_fe", framing_error_a, 1);
      check("lit_break_pulse", brk_seen_a, 1);
      send_a(8'h3C, 1'b0, 1'b1, -1);
      check("after_break_data", rx_data_a, 8'h3C);

      // 7O2: correct odd parity, second stop bit low.
      send_b(7'h55, 1'b1, 1'b1, 1'b0);
      check("lit_b55_data", rx_data_b, 7'h55);
      check("lit_b55_pe", parity_error_b, 0);
      check("lit_b55_fe", framing_error_b, 1);

      // Reset in the middle of the data bits of the next frame.
      rx_b = 1'b0; idle(BIT_CLK);
      rx_b = 1'b0; idle(BIT_CLK);
      rx_b = 1'b1; idle(BIT_CLK / 2);
      #3 reset = 1'b1;
      #1;
      check("midreset_rx_data", rx_data_b, 0);
      check("midreset_rx_valid", rx_valid_b, 0);
      check("midreset_parity_error", parity_error_b, 0);
      check("midreset_framing_error", framing_error_b, 0);
      check("midreset_break_detect", break_detect_b, 0);
      rx_b = 1'b1;
      idle(4);
      #3 reset = 1'b0;
      idle(2 * BIT_CLK);
      send_b(7'h2A, 1'b0, 1'b1, 1'b1);
      check("lit_b2a_data", rx_data_b, 7'h2A);
      check("lit_b2a_fe", framing_error_b, 0);
      check("lit_b2a_pe", parity_error_b, 0);

      idle(BIT_CLK);
      check("a_queue_empty", exp_a_q.size(), 0);
      check("b_queue_empty", exp_b_q.size(), 0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("%0d/%0d checks passed", checks_passed, checks_total + 1);
      $fatal(1, "watchdog");
   end

endmodule
